// File: rtl/fmmu_scheduler.sv
// FMMU register bank and per-datagram sequencer for logical datagrams (LRD/LWR/LRW):
// scans entries one per clock, then issues byte-wise physical bus strobes and the WKC increment.
module fmmu_scheduler #(
  parameter int         N_FMMU  = 8,
  parameter logic [7:0] CMD_LRD = 8'd10,
  parameter logic [7:0] CMD_LWR = 8'd11,
  parameter logic [7:0] CMD_LRW = 8'd12
) (
  input  logic        rxc,
  input  logic        RSTN,
  input  logic        cfg_wr,
  input  logic [7:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  output logic [7:0]  cfg_rdata,
  input  logic        dg_start,
  input  logic [7:0]  dg_cmd,
  input  logic [31:0] dg_laddr,
  input  logic [10:0] dg_len,
  input  logic        dg_abort,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        sel_valid,
  output logic [3:0]  sel_idx,
  output logic        miss,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [1:0]  wkc_inc,
  output logic        wkc_valid
);

  localparam logic [3:0] LAST_IDX = 4'(N_FMMU - 1);

  typedef enum logic [1:0] {IDLE, SCAN, XFER, DONE} state_t;

  state_t state, state_next;

  // register bank
  logic [31:0] ent_start [N_FMMU];
  logic [15:0] ent_len   [N_FMMU];
  logic [15:0] ent_phys  [N_FMMU];
  logic [1:0]  ent_type  [N_FMMU];
  logic        ent_act   [N_FMMU];

  // datagram header, latched at dg_start
  logic [7:0]  cmd_p0;
  logic [31:0] laddr_p0;
  logic [10:0] len_p0;
  logic [3:0]  scan_idx;

  // window state, latched at hit
  logic [15:0] off_p1;
  logic [15:0] rem_p1;
  logic [15:0] phys_p1;
  logic [1:0]  type_p1;
  logic [3:0]  sel_idx_p1;
  logic [10:0] byte_cnt;
  logic        rd_done;
  logic        wr_done;

  // registered bus strobe
  logic [15:0] addr_p2;
  logic [7:0]  wdata_p2;
  logic        rd_p2;
  logic        wr_p2;
  logic        miss_p2;

  logic [31:0] cur_start;
  logic [15:0] cur_len;
  logic [15:0] cur_phys;
  logic [1:0]  cur_type;
  logic        cur_act;
  logic [15:0] off_calc;
  logic        scan_hit;
  logic        scan_last_miss;
  logic        accept;
  logic        strobe_en;
  logic        rd_en;
  logic        wr_en;

  function automatic logic is_logical(input logic [7:0] cmd);
    return (cmd == CMD_LRD) || (cmd == CMD_LWR) || (cmd == CMD_LRW);
  endfunction

  function automatic logic type_ok(input logic [7:0] cmd, input logic [1:0] typ);
    logic ok;
    ok = 1'b0;
    if (cmd == CMD_LRD)      ok = typ[0];
    else if (cmd == CMD_LWR) ok = typ[1];
    else if (cmd == CMD_LRW) ok = |typ;
    return ok;
  endfunction

  // The end bound is formed at 33 bits so a window touching 0xFFFFFFFF never wraps to low addresses.
  function automatic logic entry_hit(input logic act, input logic [15:0] len,
                                     input logic [31:0] start, input logic [1:0] typ,
                                     input logic [31:0] laddr, input logic [7:0] cmd);
    logic [32:0] lim;
    lim = {1'b0, start} + {17'd0, len};
    return act && (len != 16'd0) && (laddr >= start) && ({1'b0, laddr} < lim) && type_ok(cmd, typ);
  endfunction

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < N_FMMU; i++) begin
        ent_start[i] <= '0;
        ent_len[i]   <= '0;
        ent_phys[i]  <= '0;
        ent_type[i]  <= '0;
        ent_act[i]   <= 1'b0;
      end
    end else if (cfg_wr) begin
      for (int i = 0; i < N_FMMU; i++) begin
        if (cfg_addr[7:4] == 4'(i)) begin
          case (cfg_addr[3:0])
            4'h0:    ent_start[i][7:0]   <= cfg_wdata;
            4'h1:    ent_start[i][15:8]  <= cfg_wdata;
            4'h2:    ent_start[i][23:16] <= cfg_wdata;
            4'h3:    ent_start[i][31:24] <= cfg_wdata;
            4'h4:    ent_len[i][7:0]     <= cfg_wdata;
            4'h5:    ent_len[i][15:8]    <= cfg_wdata;
            4'h8:    ent_phys[i][7:0]    <= cfg_wdata;
            4'h9:    ent_phys[i][15:8]   <= cfg_wdata;
            4'hB:    ent_type[i]         <= cfg_wdata[1:0];
            4'hC:    ent_act[i]          <= cfg_wdata[0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < N_FMMU; i++) begin
      if (cfg_addr[7:4] == 4'(i)) begin
        case (cfg_addr[3:0])
          4'h0:    cfg_rdata = ent_start[i][7:0];
          4'h1:    cfg_rdata = ent_start[i][15:8];
          4'h2:    cfg_rdata = ent_start[i][23:16];
          4'h3:    cfg_rdata = ent_start[i][31:24];
          4'h4:    cfg_rdata = ent_len[i][7:0];
          4'h5:    cfg_rdata = ent_len[i][15:8];
          4'h8:    cfg_rdata = ent_phys[i][7:0];
          4'h9:    cfg_rdata = ent_phys[i][15:8];
          4'hB:    cfg_rdata = {6'd0, ent_type[i]};
          4'hC:    cfg_rdata = {7'd0, ent_act[i]};
          default: cfg_rdata = '0;
        endcase
      end
    end
  end

  // Scan reads the live bank entry addressed by scan_idx.
  always_comb begin
    cur_start = '0;
    cur_len   = '0;
    cur_phys  = '0;
    cur_type  = '0;
    cur_act   = 1'b0;
    for (int i = 0; i < N_FMMU; i++) begin
      if (scan_idx == 4'(i)) begin
        cur_start = ent_start[i];
        cur_len   = ent_len[i];
        cur_phys  = ent_phys[i];
        cur_type  = ent_type[i];
        cur_act   = ent_act[i];
      end
    end
  end

  // Offset is below 2^16 on a hit, so the low half of the difference is exact.
  assign off_calc       = laddr_p0[15:0] - cur_start[15:0];
  assign scan_hit       = entry_hit(cur_act, cur_len, cur_start, cur_type, laddr_p0, cmd_p0);
  assign scan_last_miss = (state == SCAN) && !dg_abort && !scan_hit && (scan_idx == LAST_IDX);

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (dg_start && is_logical(dg_cmd)) state_next = SCAN;
      SCAN: begin
        if (dg_abort)                     state_next = IDLE;
        else if (scan_hit)                state_next = XFER;
        else if (scan_idx == LAST_IDX)    state_next = IDLE;
      end
      XFER: begin
        if (dg_abort)                     state_next = IDLE;
        else if (len_p0 == 11'd0)         state_next = DONE;
        else if (rx_valid) begin
          accept = 1'b1;
          if (byte_cnt + 11'd1 == len_p0) state_next = DONE;
        end
      end
      DONE:                               state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  assign strobe_en = accept && (rem_p1 != 16'd0);
  assign rd_en     = strobe_en && ((cmd_p0 == CMD_LRD) || ((cmd_p0 == CMD_LRW) && type_p1[0]));
  assign wr_en     = strobe_en && ((cmd_p0 == CMD_LWR) || ((cmd_p0 == CMD_LRW) && type_p1[1]));

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      cmd_p0     <= '0;
      laddr_p0   <= '0;
      len_p0     <= '0;
      scan_idx   <= '0;
      off_p1     <= '0;
      rem_p1     <= '0;
      phys_p1    <= '0;
      type_p1    <= '0;
      sel_idx_p1 <= '0;
      byte_cnt   <= '0;
      rd_done    <= 1'b0;
      wr_done    <= 1'b0;
      addr_p2    <= '0;
      wdata_p2   <= '0;
      rd_p2      <= 1'b0;
      wr_p2      <= 1'b0;
      miss_p2    <= 1'b0;
    end else begin
      // stage 0: header capture and scan index
      if (state == IDLE && state_next == SCAN) begin
        cmd_p0   <= dg_cmd;
        laddr_p0 <= dg_laddr;
        len_p0   <= dg_len;
        scan_idx <= '0;
      end else if (state == SCAN) begin
        scan_idx <= scan_idx + 4'd1;
      end
      // stage 1: window latched at hit, advanced per accepted byte
      if (state == SCAN && !dg_abort && scan_hit) begin
        off_p1     <= off_calc;
        rem_p1     <= cur_len - off_calc;
        phys_p1    <= cur_phys;
        type_p1    <= cur_type;
        sel_idx_p1 <= scan_idx;
        byte_cnt   <= '0;
        rd_done    <= 1'b0;
        wr_done    <= 1'b0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 11'd1;
        rd_done  <= rd_done | rd_en;
        wr_done  <= wr_done | wr_en;
        if (strobe_en) begin
          off_p1 <= off_p1 + 16'd1;
          rem_p1 <= rem_p1 - 16'd1;
        end
      end
      // stage 2: registered bus strobe and miss pulse
      rd_p2   <= rd_en;
      wr_p2   <= wr_en;
      miss_p2 <= scan_last_miss;
      if (strobe_en) begin
        addr_p2  <= phys_p1 + off_p1;
        wdata_p2 <= rx_data;
      end
    end
  end

  always_comb begin
    wkc_inc = 2'd0;
    if (state == DONE) begin
      if (cmd_p0 == CMD_LRW)       wkc_inc = {wr_done, rd_done};
      else if (rd_done || wr_done) wkc_inc = 2'd1;
    end
  end

  assign busy        = (state != IDLE);
  assign sel_valid   = (state == XFER);
  assign wkc_valid   = (state == DONE);
  assign sel_idx     = sel_idx_p1;
  assign miss        = miss_p2;
  assign bus_address = addr_p2;
  assign bus_wdata   = wdata_p2;
  assign bus_rd      = rd_p2;
  assign bus_wr      = wr_p2;

endmodule

// File: tb/tb_fmmu_scheduler.sv
// Directed and randomized checks of fmmu_scheduler against a field-level model of
// the FMMU table (first-match search, per-byte window arithmetic, WKC rules).
module tb_fmmu_scheduler;
  localparam int N = 8;
  localparam logic [7:0] LRD = 8'd10, LWR = 8'd11, LRW = 8'd12;

  logic        rxc = 1'b0, RSTN = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [7:0]  cfg_addr = '0, cfg_wdata = '0, cfg_rdata;
  logic        dg_start = 1'b0, dg_abort = 1'b0, rx_valid = 1'b0;
  logic [7:0]  dg_cmd = '0, rx_data = '0;
  logic [31:0] dg_laddr = '0;
  logic [10:0] dg_len = '0;
  logic        busy, sel_valid, miss, bus_rd, bus_wr, wkc_valid;
  logic [3:0]  sel_idx;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata;
  logic [1:0]  wkc_inc;

  fmmu_scheduler #(.N_FMMU(N)) dut (
    .rxc(rxc), .RSTN(RSTN), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .dg_start(dg_start), .dg_cmd(dg_cmd), .dg_laddr(dg_laddr),
    .dg_len(dg_len), .dg_abort(dg_abort), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .sel_valid(sel_valid), .sel_idx(sel_idx), .miss(miss),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .wkc_inc(wkc_inc), .wkc_valid(wkc_valid)
  );

  always #5 rxc = ~rxc;

  int nvec = 0;
  int nbad = 0;

  longint unsigned m_start [N];
  int              m_len   [N];
  int              m_phys  [N];
  logic [1:0]      m_type  [N];
  bit              m_act   [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_start[i] = 0; m_len[i] = 0; m_phys[i] = 0; m_type[i] = 0; m_act[i] = 0;
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge rxc);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge rxc);
    cfg_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(negedge rxc);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic set_entry(input int i, input logic [31:0] st, input logic [15:0] ln,
                           input logic [15:0] ph, input logic [1:0] ty, input bit act);
    logic [7:0] b;
    b = 8'(i << 4);
    cfg_write(b | 8'h00, st[7:0]);
    cfg_write(b | 8'h01, st[15:8]);
    cfg_write(b | 8'h02, st[23:16]);
    cfg_write(b | 8'h03, st[31:24]);
    cfg_write(b | 8'h04, ln[7:0]);
    cfg_write(b | 8'h05, ln[15:8]);
    cfg_write(b | 8'h08, ph[7:0]);
    cfg_write(b | 8'h09, ph[15:8]);
    cfg_write(b | 8'h0B, {6'd0, ty});
    cfg_write(b | 8'h0C, {7'd0, act});
    m_start[i] = st; m_len[i] = ln; m_phys[i] = ph; m_type[i] = ty; m_act[i] = act;
  endtask

  // One datagram: model prediction, drive, observe, compare.
  task automatic run_dg(input string tag, input logic [7:0] cmd, input logic [31:0] laddr,
                        input int len, input int abort_k, input bit mid_cfg, input logic [7:0] dbase);
    logic [31:0] expq[$];
    logic [31:0] obsq[$];
    longint unsigned la, off;
    int exp_idx, nacc, cyc, sent, sel_cyc, miss_cnt, miss_cyc, wkc_cnt;
    bit logi, tok, aborted, anyrd, anywr, r, w, abort_done, timeout, busy1;
    logic [1:0] exp_wkc, wkc_got;
    logic [3:0] sel_got;
    logic [15:0] a;
    logic [7:0] d;

    la = laddr;
    logi = (cmd == LRD) || (cmd == LWR) || (cmd == LRW);
    exp_idx = -1;
    if (logi) begin
      for (int i = 0; i < N; i++) begin
        tok = (cmd == LRD) ? m_type[i][0] : (cmd == LWR) ? m_type[i][1] : (m_type[i] != 2'b00);
        if (exp_idx < 0 && m_act[i] && m_len[i] != 0 && la >= m_start[i] &&
            la < m_start[i] + longint'(m_len[i]) && tok)
          exp_idx = i;
      end
    end
    aborted = (exp_idx >= 0) && (abort_k >= 0) && (abort_k < len);
    nacc = aborted ? abort_k : len;
    anyrd = 0; anywr = 0;
    if (exp_idx >= 0) begin
      for (int j = 0; j < nacc; j++) begin
        off = la - m_start[exp_idx] + longint'(j);
        if (off < longint'(m_len[exp_idx])) begin
          r = (cmd == LRD) || (cmd == LRW && m_type[exp_idx][0]);
          w = (cmd == LWR) || (cmd == LRW && m_type[exp_idx][1]);
          a = 16'(longint'(m_phys[exp_idx]) + off);
          d = w ? 8'(dbase + 8'(j)) : 8'd0;
          expq.push_back({6'd0, r, w, d, a});
          anyrd |= r; anywr |= w;
        end
      end
    end
    exp_wkc = (!anyrd && !anywr) ? 2'd0 : (cmd == LRW) ? {anywr, anyrd} : 2'd1;

    @(negedge rxc);
    dg_start = 1'b1; dg_cmd = cmd; dg_laddr = laddr; dg_len = 11'(len);
    @(negedge rxc);
    dg_start = 1'b0;
    cyc = 1; sent = 0; sel_cyc = -1; miss_cnt = 0; miss_cyc = -1; wkc_cnt = 0;
    wkc_got = 0; sel_got = 0; abort_done = 0; timeout = 0; busy1 = 0;
    while (1) begin
      rx_valid = 1'b0; dg_abort = 1'b0; cfg_wr = 1'b0;
      if (cyc == 1) busy1 = busy;
      if (bus_rd || bus_wr) obsq.push_back({6'd0, bus_rd, bus_wr, bus_wr ? bus_wdata : 8'd0, bus_address});
      if (miss) begin miss_cnt++; miss_cyc = cyc; end
      if (wkc_valid) begin wkc_cnt++; wkc_got = wkc_inc; end
      if (sel_valid && sel_cyc < 0) begin
        sel_cyc = cyc; sel_got = sel_idx;
        if (mid_cfg) begin cfg_wr = 1'b1; cfg_addr = {sel_idx, 4'h8}; cfg_wdata = 8'h55; end
      end
      if (!busy) break;
      if (cyc > 300) begin timeout = 1; break; end
      if (sel_valid && !abort_done) begin
        if (abort_k >= 0 && abort_k < len && sent == abort_k) begin
          dg_abort = 1'b1; abort_done = 1;
        end else if (sent < len && $urandom_range(0, 3) != 0) begin
          rx_valid = 1'b1; rx_data = 8'(dbase + 8'(sent)); sent++;
        end
      end
      @(negedge rxc);
      cyc++;
    end

    chk({tag, ".timeout"}, timeout, 1'b0);
    chk({tag, ".busy1"}, busy1, logi);
    chk({tag, ".sel_cyc"}, sel_cyc, (exp_idx >= 0) ? exp_idx + 2 : -1);
    if (exp_idx >= 0) chk({tag, ".sel_idx"}, sel_got, exp_idx);
    chk({tag, ".miss_cnt"}, miss_cnt, (logi && exp_idx < 0));
    if (logi && exp_idx < 0) chk({tag, ".miss_cyc"}, miss_cyc, N + 1);
    chk({tag, ".wkc_cnt"}, wkc_cnt, (exp_idx >= 0 && !aborted));
    if (exp_idx >= 0 && !aborted) chk({tag, ".wkc_inc"}, wkc_got, exp_wkc);
    chk({tag, ".nstrobe"}, obsq.size(), expq.size());
    for (int j = 0; j < expq.size() && j < obsq.size(); j++)
      chk({tag, ".strobe"}, obsq[j], expq[j]);
    if (mid_cfg && exp_idx >= 0) m_phys[exp_idx] = (m_phys[exp_idx] & 32'hFF00) | 32'h55;
  endtask

  initial begin
    int waited;
    logic [7:0] rc;
    int rl, ak;
    model_clear();
    repeat (3) @(negedge rxc);
    chk("reset.outs", {busy, sel_valid, sel_idx, miss, bus_address, bus_wdata, bus_rd, bus_wr,
                       wkc_inc, wkc_valid}, '0);
    RSTN = 1'b1;
    rd_chk("reset.bank0", 8'h00, 8'h00);
    rd_chk("reset.bank7", 8'h7C, 8'h00);

    set_entry(0, 32'h0000_1000, 16'd4, 16'h1100, 2'b01, 1'b1);
    rd_chk("rb.start1", 8'h01, 8'h10);
    rd_chk("rb.len0", 8'h04, 8'h04);
    rd_chk("rb.phys1", 8'h09, 8'h11);
    rd_chk("rb.type", 8'h0B, 8'h01);
    rd_chk("rb.act", 8'h0C, 8'h01);
    cfg_write(8'h06, 8'hAA);
    rd_chk("rb.gap", 8'h06, 8'h00);
    cfg_write(8'h85, 8'h77);
    rd_chk("rb.beyond", 8'h85, 8'h00);

    run_dg("lrd", LRD, 32'h0000_1000, 4, -1, 0, 8'h00);

    set_entry(0, 32'h0000_1000, 16'd4, 16'h1100, 2'b01, 1'b0);
    set_entry(5, 32'h0000_2000, 16'd8, 16'h1800, 2'b10, 1'b1);
    run_dg("lwr", LWR, 32'h0000_2006, 4, -1, 0, 8'hA0);

    set_entry(1, 32'h0000_0000, 16'd2, 16'h0F00, 2'b11, 1'b1);
    run_dg("lrw", LRW, 32'h0000_0000, 2, -1, 0, 8'h30);

    run_dg("miss", LRD, 32'h0000_9000, 4, -1, 0, 8'h00);
    run_dg("abort", LWR, 32'h0000_2000, 4, 1, 0, 8'hC0);
    run_dg("after_abort", LWR, 32'h0000_2001, 2, -1, 0, 8'h40);
    run_dg("midcfg", LWR, 32'h0000_2000, 2, -1, 1, 8'h50);
    run_dg("newphys", LWR, 32'h0000_2000, 1, -1, 0, 8'h60);
    run_dg("len0", LWR, 32'h0000_2000, 0, -1, 0, 8'h00);
    run_dg("other_cmd", 8'h01, 32'h0000_2000, 2, -1, 0, 8'h00);

    set_entry(1, 32'h0000_0000, 16'd2, 16'h0F00, 2'b11, 1'b0);
    set_entry(2, 32'hFFFF_FFFE, 16'd4, 16'h0300, 2'b11, 1'b1);
    run_dg("hi_hit", LRD, 32'hFFFF_FFFF, 3, -1, 0, 8'h00);
    run_dg("wrap_miss", LRD, 32'h0000_0000, 1, -1, 0, 8'h00);

    set_entry(3, 32'h0000_3000, 16'd4, 16'hFFFE, 2'b01, 1'b1);
    run_dg("phys_wrap", LRD, 32'h0000_3000, 4, -1, 0, 8'h00);

    // asynchronous reset in the middle of a transfer
    set_entry(0, 32'h0000_5000, 16'd8, 16'h0200, 2'b01, 1'b1);
    @(negedge rxc);
    cfg_addr = 8'h01;
    dg_start = 1'b1; dg_cmd = LRD; dg_laddr = 32'h0000_5000; dg_len = 11'd8;
    @(negedge rxc);
    dg_start = 1'b0;
    waited = 0;
    while (!sel_valid && waited < 20) begin @(negedge rxc); waited++; end
    chk("arst.sel", sel_valid, 1'b1);
    rx_valid = 1'b1; rx_data = 8'h11;
    @(posedge rxc);
    #2;
    chk("arst.pre_rd", {bus_rd, bus_address}, {1'b1, 16'h0200});
    chk("arst.pre_bank", cfg_rdata, 8'h50);
    RSTN = 1'b0;
    #1;
    chk("arst.outs", {busy, sel_valid, sel_idx, miss, bus_address, bus_wdata, bus_rd, bus_wr,
                      wkc_inc, wkc_valid}, '0);
    chk("arst.bank", cfg_rdata, 8'h00);
    @(negedge rxc);
    rx_valid = 1'b0;
    RSTN = 1'b1;
    model_clear();

    for (int t = 0; t < 40; t++) begin
      for (int e = 0; e < 2; e++)
        set_entry($urandom_range(0, N - 1), 32'h4000 + $urandom_range(0, 32), 16'($urandom_range(0, 12)),
                  16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       rc = 8'h01;
        1, 2, 3: rc = LRD;
        4, 5, 6: rc = LWR;
        default: rc = LRW;
      endcase
      rl = $urandom_range(0, 6);
      ak = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      run_dg($sformatf("rnd%0d", t), rc, 32'h4000 + $urandom_range(0, 48), rl, ak,
             $urandom_range(0, 5) == 0, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fmmu_scheduler.md
Name: fmmu_scheduler

Overview:
Per-datagram FMMU controller for the logical-addressing path. It holds the FMMU register bank (0x0600–0x06FF, 16 bytes per entry). On each logical datagram (LRD/LWR/LRW), it scans the entries one per clock and selects the first matching entry. It then sequences byte-wise physical bus reads and writes for the datagram payload and reports the working-counter increment. It sits between the frame parser (rx byte stream, command decode) and the process-data RAM bus.

Parameters:
N_FMMU, 8, number of FMMU entries, 1..16; scan length equals N_FMMU.
CMD_LRD, 8'd10, command code for logical read.
CMD_LWR, 8'd11, command code for logical write.
CMD_LRW, 8'd12, command code for logical read/write.

Ports:
rxc  in  1  clock; all logic on rising edge.
RSTN  in  1  asynchronous active-low reset.
cfg_wr  in  1  register-bank byte write strobe.
cfg_addr  in  8  byte offset within 0x0600 block; entry = cfg_addr[7:4], field = cfg_addr[3:0].
cfg_wdata  in  8  write data.
cfg_rdata  out  8  combinational readback of cfg_addr.
dg_start  in  1  one-cycle pulse: datagram header decoded.
dg_cmd  in  8  command, sampled at dg_start.
dg_laddr  in  32  logical start address, sampled at dg_start.
dg_len  in  11  payload length in bytes, sampled at dg_start.
dg_abort  in  1  frame error/CRC fail; cancels the current datagram.
rx_valid  in  1  one payload byte present on rx_data.
rx_data  in  8  payload byte.
busy  out  1  high in any state other than IDLE.
sel_valid  out  1  high during XFER.
sel_idx  out  4  index of the selected entry.
miss  out  1  one-cycle pulse: no entry matched.
bus_address  out  16  physical byte address.
bus_wdata  out  8  write data (registered rx_data).
bus_rd  out  1  one-cycle read strobe.
bus_wr  out  1  one-cycle write strobe.
wkc_inc  out  2  working-counter increment; valid with wkc_valid.
wkc_valid  out  1  one-cycle pulse at datagram end.

Behaviour:
Register map per entry (byte offset within the entry):
- 0–3: logical start, little-endian.
- 4–5: length.
- 8–9: physical start.
- B: type; bit0 = read, bit1 = write.
- C: activate, bit0.
- Offsets 6, 7, A, D–F: writes ignored, read 0.
- Entries at or above N_FMMU: writes ignored, read 0.

Config writes:
- Accepted in any state.
- Scan uses live register values.
- XFER uses values latched at hit, so a mid-transfer write does not affect the current transfer.

Reset:
- All outputs 0; FSM in IDLE; all register-bank bytes 0.

FSM states: IDLE, SCAN, XFER, DONE.
- IDLE: on dg_start with dg_cmd in {LRD, LWR, LRW}, latch cmd/laddr/len, set scan idx = 0, go to SCAN. Other commands are ignored. dg_start outside IDLE is ignored.
- SCAN: evaluates entry idx each cycle. Hit conditions (all required):
  - activate bit0 = 1
  - len != 0
  - laddr >= start
  - laddr < start + len, computed at 33 bits with no wrap
  - type compatible: LRD needs type bit0; LWR needs type bit1; LRW needs either bit.
- SCAN on hit: latch offset = laddr − start, window remaining = len − offset, physical start, and type; set sel_idx; go to XFER.
- SCAN on miss at idx = N_FMMU−1: pulse miss, go to IDLE.
- Latency: a hit on entry i raises sel_valid on cycle i+2 after the dg_start edge.
- XFER: on each rx_valid:
  - If window remaining > 0, drive a registered strobe the next cycle with bus_address = phys_start + offset (16-bit wrap). Assert bus_wr for LWR, or for LRW with type bit1. Assert bus_rd for LRD, or for LRW with type bit0. Both may assert together on LRW.
  - Then increment offset and decrement window remaining.
  - Bytes beyond the window produce no strobes but are still counted.
  - When the byte count reaches the latched len, go to DONE.
  - dg_len = 0: go directly to DONE on the first XFER cycle.
- DONE (one cycle): pulse wkc_valid and go to IDLE.
  - wkc_inc = 0 if no strobe occurred.
  - Otherwise: LRD → 1; LWR → 1; LRW → (read done ? 1 : 0) + (write done ? 2 : 0).
- dg_abort in SCAN or XFER: return to IDLE next cycle with no wkc_valid, no miss, and no further strobes. A strobe already registered still completes.
- rx_valid during SCAN is ignored; the parser must hold payload until sel_valid, since it has at most N_FMMU+1 cycles of header slack.

Test Plan:
- Entry 0: start 0x00001000, len 4, phys 0x1100, type 01, active. LRD laddr 0x1000, len 4, 4 bytes → sel_idx 0, sel_valid at cycle 2; bus_rd at 0x1100..0x1103; wkc_inc 1.
- Entry 0 inactive; entry 5: start 0x2000, len 8, phys 0x1800, type 10, active. LWR laddr 0x2006, len 4, data A0..A3 → sel_idx 5 (sel_valid at cycle 7); bus_wr 0x1806=A0, 0x1807=A1; no strobes for the remaining 2 bytes; wkc_inc 1.
- LRW against entry type 11 (start 0, len 2, phys 0x0F00), len 2 → bus_rd and bus_wr together at 0x0F00 and 0x0F01; wkc_inc 3.
- LRD laddr 0x9000 with no entry covering it → miss pulse 9 cycles after dg_start; busy low afterwards; no wkc_valid.
- dg_abort after the 1st byte of a 4-byte LWR hit → one bus_wr only; IDLE next cycle; no wkc_valid. A following dg_start is accepted normally.
- Entry 2 start 0xFFFFFFFE, len 4 (33-bit sum): laddr 0xFFFFFFFF hits, laddr 0x00000000 misses. Async RSTN low mid-XFER clears all outputs immediately.
